// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external SPI memory access controller: FSM encoding,
// frame geometry and the dummy byte sent in read fetch frames.
package ext_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StXfer,
        StGap,
        StDone
    } ctrl_state_e;

    localparam int unsigned FrameLen = 16;
    localparam int unsigned ByteW = FrameLen / 2;
    localparam logic [ByteW-1:0] DummyByte = 8'h00;

endpackage

// File: rtl/spi_frame_engine.sv
// Shifts one 16-bit SPI mode-0 frame (MSB first) per start pulse and returns the
// second received byte; done pulses in the cycle before CS returns high.
module spi_frame_engine
    import ext_mem_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [FrameLen-1:0] tx_word,
    output logic [ByteW-1:0]    rx_byte,
    output logic                done,
    output logic                cs,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso
);

    logic                active_q, active_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic [FrameLen-1:0] shreg_q, shreg_d;
    logic [ByteW-1:0]    rx_q, rx_d;
    logic [15:0]         div_cnt_q, div_cnt_d;
    logic [4:0]          rise_cnt_q, rise_cnt_d;
    logic                tick;

    always_comb begin
        active_d   = active_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        div_cnt_d  = div_cnt_q;
        rise_cnt_d = rise_cnt_q;
        tick       = active_q && (div_cnt_q == 16'(CLK_DIV - 1));
        done       = tick && sclk_q && (rise_cnt_q == 5'(FrameLen));

        if (!active_q) begin
            if (start) begin
                active_d   = 1'b1;
                cs_d       = 1'b0;
                shreg_d    = tx_word;
                div_cnt_d  = '0;
                rise_cnt_d = '0;
            end
        end else if (tick) begin
            div_cnt_d = '0;
            if (!sclk_q) begin
                sclk_d     = 1'b1;
                rx_d       = {rx_q[ByteW-2:0], miso};
                rise_cnt_d = rise_cnt_q + 5'd1;
            end else begin
                sclk_d = 1'b0;
                // MOSI only moves on the falling edge; cleared when CS rises.
                if (done) begin
                    active_d = 1'b0;
                    cs_d     = 1'b1;
                    shreg_d  = '0;
                end else begin
                    shreg_d = {shreg_q[FrameLen-2:0], 1'b0};
                end
            end
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            shreg_q    <= '0;
            rx_q       <= '0;
            div_cnt_q  <= '0;
            rise_cnt_q <= '0;
        end else begin
            active_q   <= active_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            div_cnt_q  <= div_cnt_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    assign cs      = cs_q;
    assign sclk    = sclk_q;
    assign mosi    = shreg_q[FrameLen-1];
    assign rx_byte = rx_q;

endmodule

// File: rtl/ext_mem_access_ctrl.sv
// Two-port arbiter in front of an SPI byte memory. Define EXT_MEM_READ_RESTORE_EN to
// write read data back after each fetch frame; otherwise reads are destructive.
module ext_mem_access_ctrl
    import ext_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic                  CS,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  busy
);

    ctrl_state_e           state_q, state_d;
    logic                  last_q, last_d;
    logic                  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_cap_q, rdata_cap_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  restore_q, restore_d;
    logic [15:0]           gap_cnt_q, gap_cnt_d;
    logic                  winner, start, frame_done, restore_pending;
    logic [ByteW-1:0]      tx_data, rx_byte;
    logic [FrameLen-1:0]   tx_word;

`ifdef EXT_MEM_READ_RESTORE_EN
    assign restore_pending = !we_q && !restore_q;
`else
    assign restore_pending = 1'b0;
`endif

    always_comb begin
        if (restore_q) begin
            tx_data = ByteW'(rdata_cap_q);
        end else if (we_q) begin
            tx_data = ByteW'(wdata_q);
        end else begin
            tx_data = DummyByte;
        end
        tx_word = {ByteW'(addr_q), tx_data};
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_cap_d = rdata_cap_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        restore_d   = restore_q;
        gap_cnt_d   = gap_cnt_q;
        start       = 1'b0;
        // On contention the requester that was not granted last wins.
        winner      = (req0_valid && req1_valid) ? !last_q : req1_valid;

        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    state_d = StGrant;
                    sel_d   = winner;
                    last_d  = winner;
                    we_d    = winner ? req1_we : req0_we;
                    addr_d  = winner ? req1_addr : req0_addr;
                    wdata_d = winner ? req1_wdata : req0_wdata;
                end
            end
            StGrant: begin
                start     = 1'b1;
                restore_d = 1'b0;
                state_d   = StXfer;
            end
            StXfer: begin
                if (frame_done) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                    if (!we_q && !restore_q) begin
                        rdata_cap_d = DATA_WIDTH'(rx_byte);
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == 16'(CS_GAP - 1)) begin
                    if (restore_pending) begin
                        start     = 1'b1;
                        restore_d = 1'b1;
                        state_d   = StXfer;
                    end else begin
                        state_d = StDone;
                        if (sel_q) begin
                            rdata1_d = we_q ? '0 : rdata_cap_q;
                        end else begin
                            rdata0_d = we_q ? '0 : rdata_cap_q;
                        end
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_cap_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            restore_q   <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_cap_q <= rdata_cap_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            restore_q   <= restore_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    spi_frame_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_word (tx_word),
        .rx_byte (rx_byte),
        .done    (frame_done),
        .cs      (CS),
        .sclk    (SCLK),
        .mosi    (MOSI),
        .miso    (MISO)
    );

    assign req0_ready  = (state_q == StGrant) && !sel_q;
    assign req1_ready  = (state_q == StGrant) && sel_q;
    assign resp0_valid = (state_q == StDone) && !sel_q;
    assign resp1_valid = (state_q == StDone) && sel_q;
    assign resp0_rdata = rdata0_q;
    assign resp1_rdata = rdata1_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ext_mem_access_ctrl.sv
// Directed bench for ext_mem_access_ctrl with a behavioural SPI byte-memory slave.
// Expectations follow EXT_MEM_READ_RESTORE_EN when it is defined for the build.
module tb_ext_mem_access_ctrl;

`ifdef EXT_MEM_READ_RESTORE_EN
    localparam bit Restore = 1'b1;
`else
    localparam bit Restore = 1'b0;
`endif
    localparam int RdFrames = Restore ? 2 : 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [7:0] resp0_rdata, resp1_rdata;
    logic CS, SCLK, MOSI, MISO, busy;

    always #5 clk = ~clk;

    ext_mem_access_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .CLK_DIV    (2),
        .CS_GAP     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .resp0_valid (resp0_valid),
        .resp0_rdata (resp0_rdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .resp1_valid (resp1_valid),
        .resp1_rdata (resp1_rdata),
        .CS          (CS),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .busy        (busy)
    );

    // Slave model and bus monitor, sampled on the falling clk edge.
    logic [7:0]  mem [256];
    logic        mem_init = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] s_in = '0;
    logic [7:0]  s_out = '0;
    int          s_bits = 0;
    int          cs_low_run = 0, cs_high_run = 0, sclk_err = 0;
    int          resp_cnt [2] = '{0, 0};
    logic [7:0]  resp_rd [2];
    logic [15:0] frames [$];
    int          cs_lows [$];
    int          gaps [$];

    assign MISO = s_out[7];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem_init = 1'b1;
        end
        if (prev_cs && !CS) begin
            if (frames.size() > 0) gaps.push_back(cs_high_run);
            cs_low_run = 0;
            s_bits = 0;
            s_in = '0;
            s_out = '0;
        end
        if (!prev_cs && CS) begin
            if (s_bits == 16) begin
                mem[s_in[15:8]] = s_in[7:0];
                frames.push_back(s_in);
                cs_lows.push_back(cs_low_run);
            end
            cs_high_run = 0;
        end
        if (!CS && !prev_sclk && SCLK) begin
            s_in = {s_in[14:0], MOSI};
            s_bits++;
        end
        if (!CS && prev_sclk && !SCLK) begin
            if (s_bits == 8) s_out = mem[s_in[7:0]];
            else s_out = {s_out[6:0], 1'b0};
        end
        if (!CS) cs_low_run++;
        else cs_high_run++;
        if (CS && SCLK) sclk_err++;
        if (resp0_valid) begin resp_cnt[0]++; resp_rd[0] = resp0_rdata; end
        if (resp1_valid) begin resp_cnt[1]++; resp_rd[1] = resp1_rdata; end
        prev_cs = CS;
        prev_sclk = SCLK;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic drive(input int n, input logic v, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (n == 0) begin
            req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy && c < 1000) begin step(); c++; end
        if (busy) timeout(name);
        step(); step();
    endtask

    task automatic run_txn(input int n, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata);
        int c = 0;
        int r0 = resp_cnt[n];
        drive(n, 1'b1, we, addr, wdata);
        do begin step(); c++; end while (!rdy(n) && c < 200);
        if (!rdy(n)) timeout("ready");
        drive(n, 1'b0, 1'b0, 8'h00, 8'h00);
        c = 0;
        while (resp_cnt[n] == r0 && c < 1000) begin step(); c++; end
        if (resp_cnt[n] == r0) timeout("resp");
        wait_idle("idle");
    endtask

    typedef struct {
        int         req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_frames;
        logic [7:0] exp_mem;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int f0, g0, r0, r1, c, ng;
        int order [4];
        logic [7:0] a;

        vecs[0] = '{0, 1'b1, 8'h12, 8'hA5, 8'h00, 1, 8'hA5};
        vecs[1] = '{1, 1'b0, 8'h12, 8'h00, 8'hA5, RdFrames, Restore ? 8'hA5 : 8'h00};
        vecs[2] = '{0, 1'b1, 8'h34, 8'h5C, 8'h00, 1, 8'h5C};
        vecs[3] = '{1, 1'b1, 8'hFF, 8'h3C, 8'h00, 1, 8'h3C};
        vecs[4] = '{0, 1'b0, 8'h34, 8'h00, 8'h5C, RdFrames, Restore ? 8'h5C : 8'h00};
        vecs[5] = '{1, 1'b0, 8'h12, 8'h00, Restore ? 8'hA5 : 8'h00, RdFrames,
                    Restore ? 8'hA5 : 8'h00};
        vecs[6] = '{0, 1'b1, 8'h00, 8'hFF, 8'h00, 1, 8'hFF};
        vecs[7] = '{1, 1'b0, 8'h00, 8'h00, 8'hFF, RdFrames, Restore ? 8'hFF : 8'h00};

        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_cs", CS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_resp", {resp0_valid, resp1_valid}, 0);
        check("rst_rdata", {resp0_rdata, resp1_rdata}, 0);

        // Both requesters held valid: grants must alternate starting with req0.
        drive(0, 1'b1, 1'b1, 8'h80, 8'h11);
        drive(1, 1'b1, 1'b1, 8'h90, 8'h22);
        ng = 0;
        c = 0;
        while (ng < 4 && c < 2000) begin
            step();
            c++;
            if (req0_ready) begin order[ng] = 0; ng++; end
            else if (req1_ready) begin order[ng] = 1; ng++; end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("arb_grants", ng, 4);
        for (int i = 0; i < ng; i++) check($sformatf("arb_order%0d", i), order[i], i % 2);
        wait_idle("arb_idle");

        for (int i = 0; i < 8; i++) begin
            f0 = frames.size();
            g0 = gaps.size();
            r0 = resp_cnt[0];
            r1 = resp_cnt[1];
            run_txn(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_rdata", i), resp_rd[vecs[i].req], vecs[i].exp_rdata);
            check($sformatf("v%0d_resp_own", i),
                  (vecs[i].req == 0) ? resp_cnt[0] - r0 : resp_cnt[1] - r1, 1);
            check($sformatf("v%0d_resp_other", i),
                  (vecs[i].req == 0) ? resp_cnt[1] - r1 : resp_cnt[0] - r0, 0);
            check($sformatf("v%0d_frames", i), frames.size() - f0, vecs[i].exp_frames);
            if (frames.size() > f0) begin
                check($sformatf("v%0d_frame0", i), frames[f0],
                      {vecs[i].addr, vecs[i].we ? vecs[i].wdata : 8'h00});
                check($sformatf("v%0d_cs_low", i), cs_lows[f0], 64);
            end
            if (vecs[i].exp_frames == 2 && frames.size() > f0 + 1) begin
                check($sformatf("v%0d_frame1", i), frames[f0 + 1],
                      {vecs[i].addr, vecs[i].exp_rdata});
                check($sformatf("v%0d_gap", i), (gaps.size() > g0) ? gaps[g0] : -1, 2);
            end
            a = vecs[i].addr;
            check($sformatf("v%0d_mem", i), mem[a], vecs[i].exp_mem);
        end

        // Reset after the 7th SCLK rise of a write aborts it silently.
        r0 = resp_cnt[0];
        drive(0, 1'b1, 1'b1, 8'h40, 8'h77);
        c = 0;
        do begin step(); c++; end while (!req0_ready && c < 200);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        c = 0;
        while (!(s_bits == 7 && !CS) && c < 200) begin step(); c++; end
        if (!(s_bits == 7 && !CS)) timeout("abort_wait");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", CS, 1);
        check("abort_sclk", SCLK, 0);
        check("abort_busy", busy, 0);
        check("abort_mosi", MOSI, 0);
        check("abort_rdata1", resp1_rdata, 0);
        step();
        reset = 1'b0;
        repeat (20) step();
        check("abort_no_resp", resp_cnt[0] - r0, 0);

        // Pointer must be back at 1, so req0 wins again after reset.
        drive(0, 1'b1, 1'b1, 8'hA0, 8'h01);
        drive(1, 1'b1, 1'b1, 8'hB0, 8'h02);
        c = 0;
        do begin step(); c++; end while (!req0_ready && !req1_ready && c < 200);
        check("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle("post_rst_idle");

        check("sclk_while_cs_high", sclk_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_mem_access_ctrl.md
EXT_MEM_ACCESS_CTRL -- requirements
Module: ext_mem_access_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 8, address byte width; DATA_WIDTH, default 8, data byte width; CLK_DIV, default 2, SCLK half-period in clk cycles (>=1); CS_GAP, default 2, CS-high cycles between frames (>=1).
REQ-002 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-003 SHALL have ports, for n = 0, 1:
- reqn_valid, input, 1, request pending
- reqn_ready, output, 1, one-cycle accept pulse
- reqn_we, input, 1, 1 = write, 0 = read
- reqn_addr, input, ADDR_WIDTH, memory address
- reqn_wdata, input, DATA_WIDTH, write data
- respn_valid, output, 1, one-cycle completion pulse
- respn_rdata, output, DATA_WIDTH, read data (0 for writes)
REQ-004 SHALL have SPI and status ports:
- CS, output, 1, active-low chip select
- SCLK, output, 1, serial clock
- MOSI, output, 1, serial data out
- MISO, input, 1, serial data in
- busy, output, 1, high in every state except IDLE

Function
REQ-005 SHALL drive SPI mode 0, MSB first: SCLK idles low; MOSI changes only while SCLK is low; MISO is sampled on each SCLK rising edge.
REQ-006 SHALL make each frame exactly 16 SCLK cycles with CS low: address byte, then data byte; the device commits the second byte of every frame to memory.
REQ-007 SHALL make the SCLK period 2*CLK_DIV clk cycles. The first rising edge SHALL occur CLK_DIV cycles after CS falls. CS SHALL rise CLK_DIV cycles after the 16th rising edge, coincident with SCLK returning low.
REQ-008 SHALL use FSM states IDLE, GRANT, XFER, GAP, DONE:
- IDLE->GRANT when any reqn_valid
- GRANT->XFER after 1 cycle
- XFER->GAP at CS rise
- GAP->XFER (restore frame) or GAP->DONE after CS_GAP cycles
- DONE->IDLE after 1 cycle
REQ-009 SHALL arbitrate in IDLE as follows: a sole requester wins; if both are valid, the requester not granted last wins; the last-granted pointer resets to 1, so req0 wins first.
REQ-010 SHALL pulse reqn_ready for exactly one cycle on entry to GRANT and latch we/addr/wdata then; requesters hold valid and payload until ready.
REQ-011 SHALL transmit a write as one frame (addr, wdata) and set respn_rdata to 0.
REQ-012 SHALL transmit a read as a fetch frame (addr, 0x00), capturing the second MISO byte as rdata (see REQ-017 for the restore frame).
REQ-013 SHALL pulse respn_valid for one cycle in DONE for the granted requester only; respn_rdata SHALL hold its value until that requester's next response.
REQ-014 SHALL keep reqn_ready low outside IDLE->GRANT; requests arriving during a transaction wait, and none are dropped.

Reset
REQ-015 SHALL, while reset is sampled high, force the following next cycle: state IDLE, CS=1, SCLK=0, MOSI=0, all ready/resp_valid=0, respn_rdata=0, busy=0, pointer=1.
REQ-016 SHALL, on reset mid-frame, abort the transaction with no response pulse; the memory content at that address is then undefined.

Configuration
REQ-017 SHALL, with EXT_MEM_READ_RESTORE_EN defined, follow the read fetch frame with GAP and then a restore frame (addr, captured rdata) before DONE; without it, a read SHALL be the fetch frame only, leaving 0x00 written at addr (destructive read).

Structure
REQ-018 SHALL place the FSM state encoding, frame length (16), and the dummy byte (0x00) in shared package ext_mem_pkg.
REQ-019 SHALL use one sub-module, spi_frame_engine (CLK_DIV): start pulse, 16-bit tx word in, 8-bit rx byte out, done pulse, driving CS/SCLK/MOSI.

Verification (CLK_DIV=2, CS_GAP=2, behavioural slave model)
REQ-020 SHALL cover: req0 write addr 0x12 data 0xA5 -> one frame with MOSI 0x12,0xA5, 64 SCLK-active cycles, resp0_valid single pulse, resp0_rdata=0x00.
REQ-021 SHALL cover: macro defined, mem[0x12]=0xA5, req1 read 0x12 -> frames (0x12,0x00) then (0x12,0xA5), resp1_rdata=0xA5, mem[0x12]=0xA5 afterwards.
REQ-022 SHALL cover: macro undefined, same read -> single frame, resp1_rdata=0xA5, mem[0x12]=0x00.
REQ-023 SHALL cover: req0 and req1 valid in the same cycle after reset -> req0 granted first, then req1; with both continuously valid, grants strictly alternate 0,1,0,1.
REQ-024 SHALL cover: reset asserted after the 7th SCLK rise -> next cycle CS=1, SCLK=0, busy=0, no resp pulse.
REQ-025 SHALL cover: CS-high gap between the fetch and restore frames = CS_GAP cycles; SCLK never toggles while CS=1.
